mod_m_counter_prog: RTL and testbench

- Runtime-programmable modulo counter. Generalises the fixed-modulus counter with:
  - a programmable terminal value, double-buffered so a change takes effect at the next wrap;
  - up/down counting;
  - a one-shot mode;
  - synchronous clear and preload.
- Drives BRAM address sequencing and frame/symbol timing in the DSP path, where modulus changes at runtime (tap count, block length).

---
 rtl/dsp_cnt_pkg.sv | 14 +
 rtl/term_shadow_reg.sv | 48 ++++
 rtl/mod_m_counter_prog.sv | 83 ++++++++
 tb/tb_mod_m_counter_prog.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_cnt_pkg.sv
// Shared constants and helpers for the programmable DSP-path counters.
package dsp_cnt_pkg;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DN       = 1'b1;

    // Counter width for a given modulus: $clog2, never narrower than one bit.
    function automatic int cnt_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/term_shadow_reg.sv
// Double-buffered terminal value: a clamped shadow register plus a pending
// flag, copied into the active terminal value whenever the counter asserts apply.
module term_shadow_reg
    import dsp_cnt_pkg::*;
#(
    parameter int   M_MAX     = 1024,
    parameter int   M_DEFAULT = 32,
    localparam int  W         = cnt_width(M_MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         term_wr,
    input  logic [W-1:0] term_in,
    input  logic         apply,
    output logic [W-1:0] term_q,
    output logic [W-1:0] shadow_q,
    output logic         pend
);

    localparam logic [W-1:0] TERM_LIM = W'(M_MAX - 1);
    localparam logic [W-1:0] TERM_DEF = W'(M_DEFAULT - 1);

    logic [W-1:0] term_clamped;

    assign term_clamped = (term_in > TERM_LIM) ? TERM_LIM : term_in;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that held before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q   <= TERM_DEF;
            shadow_q <= TERM_DEF;
            pend     <= 1'b0;
        end else begin
            // apply copies the shadow as it stood before this cycle's write,
            // so a write landing on a wrap stays pending for the next one.
            if (apply)
                term_q <= shadow_q;
            if (term_wr) begin
                shadow_q <= term_clamped;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable modulo counter: up/down, wrap or one-shot, with
// synchronous clear/preload and a double-buffered terminal value.
module mod_m_counter_prog
    import dsp_cnt_pkg::*;
#(
    parameter int   M_MAX     = 1024,
    parameter int   M_DEFAULT = 32,
    localparam int  W         = cnt_width(M_MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         run,
    input  logic         dir,
    input  logic         mode,
    input  logic         term_wr,
    input  logic [W-1:0] term_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         max,
    output logic         done,
    output logic [W-1:0] term_q,
    output logic         pend
);

    logic [W-1:0] shadow_q;
    logic [W-1:0] start_val;
    logic [W-1:0] load_clamped;
    logic         at_term;
    logic         wrap;
    logic         apply;

    term_shadow_reg #(
        .M_MAX     (M_MAX),
        .M_DEFAULT (M_DEFAULT)
    ) u_term (
        .clk      (clk),
        .rst_n    (rst_n),
        .term_wr  (term_wr),
        .term_in  (term_in),
        .apply    (apply),
        .term_q   (term_q),
        .shadow_q (shadow_q),
        .pend     (pend)
    );

    // NOTE: every signal written here is assigned on every path, so no latch
    // can be inferred.
    always_comb begin
        // Counting up, anything at or beyond term_q is treated as terminal.
        at_term      = (dir == DIR_DN) ? (q == '0) : (q >= term_q);
        wrap         = run & at_term & ~done & ~clr & ~load;
        apply        = clr | wrap | done | ~run;
        // Only used on clr or wrap, where apply is high and the shadow
        // becomes the new term_q (it equals term_q when nothing is pending).
        start_val    = (dir == DIR_DN) ? shadow_q : '0;
        load_clamped = (load_val > term_q) ? term_q : load_val;
    end

    assign max = wrap & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            done <= 1'b0;
        end else if (clr) begin
            q    <= start_val;
            done <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            done <= 1'b0;
        end else if (wrap) begin
            if (mode == MODE_ONESHOT)
                done <= 1'b1;
            else
                q <= start_val;
        end else if (run && !done) begin
            q <= (dir == DIR_DN) ? q - W'(1) : q + W'(1);
        end
    end

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Self-checking bench for mod_m_counter_prog: directed tables and sequences
// plus randomized traffic against a behavioural model of the counter rules.
module tb_mod_m_counter_prog;

    localparam int M_MAX = 1024;
    localparam int M_DEF = 32;
    localparam int W     = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0, run = 1'b0, dir = 1'b0, mode = 1'b0;
    logic         term_wr = 1'b0, load = 1'b0;
    logic [W-1:0] term_in = '0, load_val = '0;
    logic [W-1:0] q, term_q;
    logic         max, done, pend;

    // Second instance with a modulus limit that is not a power of two.
    logic [4:0]   s_term_in = '0, s_load_val = '0;
    logic [4:0]   s_q, s_term_q;
    logic         s_max, s_done, s_pend;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    int m_q, m_term, m_shadow;
    bit m_pend, m_done;

    typedef struct {
        logic         clr, run, dir, mode, term_wr, load;
        logic [W-1:0] term_in, load_val;
        int           eq, emx, edn, etq, epd;
    } vec_t;
    vec_t tbl[$];

    mod_m_counter_prog #(.M_MAX(M_MAX), .M_DEFAULT(M_DEF)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .dir(dir), .mode(mode),
        .term_wr(term_wr), .term_in(term_in), .load(load), .load_val(load_val),
        .q(q), .max(max), .done(done), .term_q(term_q), .pend(pend)
    );

    mod_m_counter_prog #(.M_MAX(20), .M_DEFAULT(20)) dut_small (
        .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .dir(dir), .mode(mode),
        .term_wr(term_wr), .term_in(s_term_in), .load(load), .load_val(s_load_val),
        .q(s_q), .max(s_max), .done(s_done), .term_q(s_term_q), .pend(s_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_term = M_DEF - 1; m_shadow = M_DEF - 1; m_pend = 0; m_done = 0;
    endfunction

    function automatic bit model_max();
        bit at_t;
        at_t = dir ? (m_q == 0) : (m_q >= m_term);
        return rst_n && run && !m_done && !clr && !load && at_t;
    endfunction

    // Advance the model by one clock using the inputs held across the edge.
    function automatic void model_step();
        bit wrap, apply;
        int new_term, start;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wrap     = model_max();
        apply    = clr || wrap || m_done || !run;
        new_term = apply ? m_shadow : m_term;
        start    = dir ? new_term : 0;
        if (clr) begin
            m_q = start; m_done = 0;
        end else if (load) begin
            m_q = (int'(load_val) > m_term) ? m_term : int'(load_val); m_done = 0;
        end else if (wrap) begin
            if (mode) m_done = 1;
            else      m_q = start;
        end else if (run && !m_done) begin
            m_q = dir ? m_q - 1 : m_q + 1;
        end
        m_term = new_term;
        if (term_wr) begin
            m_shadow = (int'(term_in) > M_MAX - 1) ? M_MAX - 1 : int'(term_in);
            m_pend   = 1;
        end else if (apply) begin
            m_pend = 0;
        end
    endfunction

    // Called at posedge+1; moves to mid-cycle and compares against the model.
    task automatic half(input string tag);
        #4;
        check({tag, ".q"},    q,      m_q);
        check({tag, ".max"},  max,    model_max());
        check({tag, ".done"}, done,   m_done);
        check({tag, ".term"}, term_q, m_term);
        check({tag, ".pend"}, pend,   m_pend);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic c, r, d, m, tw, input int ti, input logic ld, input int lv);
        clr = c; run = r; dir = d; mode = m; term_wr = tw; load = ld;
        term_in = W'(ti); load_val = W'(lv);
    endtask

    function automatic void add(input bit c, r, d, m, tw, input int ti, input bit ld,
                                input int lv, input int eq, emx, edn, etq, epd);
        vec_t v;
        v.clr = c; v.run = r; v.dir = d; v.mode = m; v.term_wr = tw; v.load = ld;
        v.term_in = W'(ti); v.load_val = W'(lv);
        v.eq = eq; v.emx = emx; v.edn = edn; v.etq = etq; v.epd = epd;
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();

        // One-shot down, done hold, load restart, then priority and load clamp.
        //   c r d m tw ti ld lv   q mx dn tq pd
        add(0,0,0,0,1, 4,0, 0,   0, 0, 0, 7, 0);
        add(0,0,0,0,0, 0,0, 0,   0, 0, 0, 7, 1);
        add(1,0,1,1,0, 0,0, 0,   0, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   4, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   3, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   2, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   1, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   0, 1, 0, 4, 0);
        for (int i = 0; i < 10; i++)
            add(0,1,1,1,0, 0,0, 0,   0, 0, 1, 4, 0);
        add(0,1,1,1,0, 0,1, 2,   0, 0, 1, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   2, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   1, 0, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   0, 1, 0, 4, 0);
        add(0,1,1,1,0, 0,0, 0,   0, 0, 1, 4, 0);
        add(1,1,0,0,0, 0,1, 3,   0, 0, 1, 4, 0);
        add(0,0,0,0,1, 7,0, 0,   0, 0, 0, 4, 0);
        add(0,0,0,0,0, 0,0, 0,   0, 0, 0, 4, 1);
        add(0,0,0,0,0, 0,0, 0,   0, 0, 0, 7, 0);
        add(0,0,0,0,0, 0,1,50,   0, 0, 0, 7, 0);
        add(0,1,0,0,0, 0,0, 0,   7, 1, 0, 7, 0);
        add(0,1,0,0,0, 0,0, 0,   0, 0, 0, 7, 0);

        // Reset values, then an asynchronous reset in the middle of a count.
        @(posedge clk); #1;
        half("rst");
        check("rst.q0", q, 0); check("rst.term31", term_q, 31); check("rst.max0", max, 0);
        clk_edge();
        rst_n = 1'b1;
        set_in(0,1,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++) begin half("pre"); clk_edge(); end
        #2 rst_n = 1'b0;
        #1 check("async_rst.q", q, 0);
        model_reset();
        half("inrst");
        clk_edge();
        rst_n = 1'b1;

        // Default modulus 32.
        for (int i = 0; i < 74; i++) begin
            half("cnt32");
            check("cnt32.q", q, i % 32);
            check("cnt32.max", max, (i % 32) == 31);
            clk_edge();
        end

        // Shadowed modulus change requested at q = 10.
        set_in(0,1,0,0,1,7,0,0);
        half("wr7");
        check("wr7.q", q, 10);
        clk_edge();
        term_wr = 1'b0;
        for (int j = 11; j < 32; j++) begin
            half("pend7");
            check("pend7.q", q, j);
            check("pend7.pend", pend, 1);
            check("pend7.term", term_q, 31);
            clk_edge();
        end
        for (int k = 0; k < 24; k++) begin
            half("cnt8");
            check("cnt8.q", q, k % 8);
            check("cnt8.max", max, (k % 8) == 7);
            check("cnt8.term", term_q, 7);
            clk_edge();
        end

        foreach (tbl[i]) begin
            set_in(tbl[i].clr, tbl[i].run, tbl[i].dir, tbl[i].mode, tbl[i].term_wr,
                   int'(tbl[i].term_in), tbl[i].load, int'(tbl[i].load_val));
            half($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.q", i),    q,      tbl[i].eq);
            check($sformatf("tbl%0d.max", i),  max,    tbl[i].emx);
            check($sformatf("tbl%0d.done", i), done,   tbl[i].edn);
            check($sformatf("tbl%0d.term", i), term_q, tbl[i].etq);
            check($sformatf("tbl%0d.pend", i), pend,   tbl[i].epd);
            clk_edge();
        end

        // Terminal value clamp, on both instances.
        set_in(0,0,0,0,1,1023,0,0);
        s_term_in = 5'd31;
        half("clampwr"); clk_edge();
        term_wr = 1'b0;
        half("clampwait"); clk_edge();
        half("clamp");
        check("clamp.term1023", term_q, 1023);
        check("clamp.small_term19", s_term_q, 19);
        clk_edge();

        // Modulus 1: q pinned at 0, max follows run.
        set_in(1,0,0,0,1,0,0,0);
        half("m1wr"); clk_edge();
        set_in(0,0,0,0,0,0,0,0);
        half("m1wait"); clk_edge();
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            half("m1run");
            check("m1.q", q, 0);
            check("m1.max", max, 1);
            clk_edge();
        end
        for (int i = 0; i < 3; i++) begin
            run = (i != 1);
            half("m1tog");
            check("m1tog.max", max, i != 1);
            clk_edge();
        end
        set_in(1,0,0,1,0,0,0,0);
        half("m1clr"); clk_edge();
        run = 1'b1; clr = 1'b0;
        half("m1os");
        check("m1os.max", max, 1);
        check("m1os.done", done, 0);
        clk_edge();
        half("m1os2");
        check("m1os2.done", done, 1);
        clk_edge();

        // Async reset while a shadow write is pending.
        set_in(0,1,0,0,1,9,0,0);
        half("pwr"); clk_edge();
        term_wr = 1'b0;
        #1 check("prst.pend_before", pend, 1);
        rst_n = 1'b0;
        #1;
        check("prst.q", q, 0); check("prst.term", term_q, 31);
        check("prst.pend", pend, 0); check("prst.done", done, 0); check("prst.max", max, 0);
        model_reset();
        half("prst_hold"); clk_edge();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 29) == 0);
            run      = ($urandom_range(0, 99) < 85);
            term_wr  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 63) == 0) dir  = ~dir;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            term_in  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1023))
                                                   : W'($urandom_range(0, 12));
            load_val = W'($urandom_range(0, 20));
            s_term_in = 5'($urandom_range(0, 31));
            half("rand");
            clk_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
